// File: rtl/div_tc_32_16.sv
// Iterative signed divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Optional build macro DIV_SAT_EN: saturate the quotient on overflow instead of wrapping.
module div_tc_32_16 #(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     quotient,
  output logic [DW-1:0]     remainder,
  output logic              ovf,
  output logic              dz,
  output logic [1:0]        dbg_state
);

  // Handshake: start is sampled only while busy=0; done pulses for one cycle and the
  // result outputs hold until the next done. A start in the done cycle is accepted.

  localparam int CW = $clog2(2 * DW);
  localparam logic [CW-1:0] LAST = CW'(2 * DW - 1);
  localparam logic [2*DW-1:0] QMAX_POS = {{(DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic [2*DW-1:0] QMAX_NEG = {{DW{1'b0}}, 1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2*DW-1:0]   qm;
  logic [DW-1:0]     rm;
  logic [DW-1:0]     dvs;
  logic [DW-1:0]     dvd_lo;
  logic              neg_q;
  logic              neg_r;

  assign dbg_state = state;

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [DW:0]   rem_sh;
  logic          rem_ge;
  logic [DW-1:0] rem_sub;

  assign rem_sh  = {rm, qm[2*DW-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvs});
  assign rem_sub = rem_sh[DW-1:0] - dvs;

  logic          q_ovf;
  logic [DW-1:0] q_lo;
  logic [DW-1:0] q_ovf_val;
  logic [DW-1:0] r_signed;

  always_comb begin
    q_lo      = neg_q ? (~qm[DW-1:0] + 1'b1) : qm[DW-1:0];
    q_ovf     = neg_q ? (qm > QMAX_NEG) : (qm > QMAX_POS);
    r_signed  = neg_r ? (~rm + 1'b1) : rm;
`ifdef DIV_SAT_EN
    q_ovf_val = neg_q ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
`else
    q_ovf_val = q_lo;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      count     <= '0;
      qm        <= '0;
      rm        <= '0;
      dvs       <= '0;
      dvd_lo    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            qm     <= dividend[2*DW-1] ? (~dividend + 1'b1) : dividend;
            dvs    <= divisor[DW-1] ? (~divisor + 1'b1) : divisor;
            rm     <= '0;
            neg_q  <= dividend[2*DW-1] ^ divisor[DW-1];
            neg_r  <= dividend[2*DW-1];
            dvd_lo <= dividend[DW-1:0];
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          qm    <= {qm[2*DW-2:0], rem_ge};
          rm    <= rem_ge ? rem_sub : rem_sh[DW-1:0];
          count <= count + 1'b1;
          if (count == LAST) state <= SIGN;
        end
        SIGN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          // A zero divisor still runs the full CALC pass so latency is fixed; its result is dropped.
          if (dvs == '0) begin
            dz        <= 1'b1;
            ovf       <= 1'b1;
            quotient  <= '0;
            remainder <= dvd_lo;
          end else begin
            dz        <= 1'b0;
            ovf       <= q_ovf;
            quotient  <= q_ovf ? q_ovf_val : q_lo;
            remainder <= r_signed;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_tc_32_16.sv
// Scoreboard bench for div_tc_32_16: directed vectors, expected results queued at issue,
// checked by an independent monitor on each done pulse (result and latency).
module tb_div_tc_32_16;

  localparam int DW  = 16;
  localparam int LAT = 2 * DW + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2*DW-1:0] dividend = '0;
  logic [DW-1:0]   divisor = '0;
  logic            busy, done, ovf, dz;
  logic [DW-1:0]   quotient, remainder;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  int last_done_edge = 0;
  int last_acc_edge = 0;
  int done_seen = 0;

  logic [2*DW+1:0] exp_q[$];
  int              acc_q[$];

  div_tc_32_16 #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dz(dz), .dbg_state(dbg_state)
  );

  // clock / reset-independent edge counter
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [2*DW+1:0] got;
      logic [2*DW+1:0] exp;
      int              acc;
      done_seen = done_seen + 1;
      got = {quotient, remainder, ovf, dz};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got q=%h r=%h ovf=%b dz=%b, no result expected",
                 quotient, remainder, ovf, dz);
      end else begin
        exp = exp_q.pop_front();
        acc = acc_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result: got q=%h r=%h ovf=%b dz=%b, want q=%h r=%h ovf=%b dz=%b",
                   quotient, remainder, ovf, dz,
                   exp[2*DW+1:DW+2], exp[DW+1:2], exp[1], exp[0]);
        end
        checks++;
        if (ecount - acc + 1 != LAT) begin
          errors++;
          $display("FAIL latency: got %0d edges, want %0d", ecount - acc + 1, LAT);
        end
      end
      last_done_edge = ecount;
    end
  end

  task automatic issue(input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] eq, input logic [DW-1:0] er,
                       input logic eo, input logic ed);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: busy still %b after %0d cycles, want 0", busy, w);
      return;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back({eq, er, eo, ed});
    @(posedge clk);
    #1;
    acc_q.push_back(ecount);
    last_acc_edge = ecount;
    start = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check_val({name, "_outs"}, {quotient ^ remainder}, '0);
    check_val({name, "_q"}, quotient, '0);
    check_val({name, "_flags"}, {12'd0, busy, done, ovf, dz}, '0);
    check_val({name, "_state"}, {14'd0, dbg_state}, '0);
  endtask

  initial begin
    logic [DW-1:0] sat_pos_ovf_q;
    logic [DW-1:0] sat_8000_q;
    int            w;
`ifdef DIV_SAT_EN
    sat_pos_ovf_q = 16'h7FFF;
    sat_8000_q    = 16'h7FFF;
`else
    sat_pos_ovf_q = 16'h0000;
    sat_8000_q    = 16'h8000;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    #1 rst = 1'b0;

    // main vectors, issued back-to-back
    issue(32'hCFC06080, 16'h8001, 16'h6080, 16'h0000, 1'b0, 1'b0);
    issue(32'h3FFF0001, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (last_acc_edge != last_done_edge + 1) begin
      errors++;
      $display("FAIL back_to_back: accept edge %0d, want %0d", last_acc_edge, last_done_edge + 1);
    end
    issue(32'h3FFF0001, 16'h8001, 16'h8001, 16'h0000, 1'b0, 1'b0);
    issue(32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    issue(32'h00000007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
    issue(32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0);
    issue(32'hFFFFFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
    issue(32'h40000000, 16'h0001, sat_pos_ovf_q, 16'h0000, 1'b1, 1'b0);
    issue(32'h80000000, 16'hFFFF, sat_pos_ovf_q, 16'h0000, 1'b1, 1'b0);
    issue(32'hFFFF8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0);
    issue(32'h40000000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0);
    issue(32'h00008000, 16'h0001, sat_8000_q, 16'h0000, 1'b1, 1'b0);
    issue(32'h00001234, 16'h0000, 16'h0000, 16'h1234, 1'b1, 1'b1);
    issue(32'hFFFF8765, 16'h0000, 16'h0000, 16'h8765, 1'b1, 1'b1);

    // start while busy at edge 5 is ignored
    issue(32'hCFC06080, 16'h8001, 16'h6080, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    dividend = 32'h00000064;
    divisor  = 16'h0007;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // reset at edge 10 of an operation: no done, all outputs cleared
    issue(32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0);
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    dividend = 32'hFFFFFFF9;
    divisor  = 16'h0002;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    done_seen = 0;
    @(negedge clk);
    check_idle_zero("midreset");
    repeat (LAT + 10) @(negedge clk);
    check_val("midreset_no_done", 16'(done_seen), 16'd0);

    // a fresh operation works after the abort
    issue(32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_val("drain", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
